// File: rtl/alu_op_sequencer.sv
// Initiator side of the 8-bit ALU operand/result interface: queues host commands,
// issues them to the ALU core one at a time and returns result/flags or a timeout marker.
//
// state | meaning
// IDLE  | no op in flight; pops the FIFO head into the ALU operand regs when available
// ISSUE | one-cycle alu_req pulse; wait timer armed
// WAIT  | waiting for alu_done or the timer terminal count
// RESP  | response held on rsp_* until rsp_ready
module alu_op_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int OP_W       = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [OP_W-1:0]               cmd_op,
    input  logic [7:0]                    cmd_a,
    input  logic [7:0]                    cmd_b,
    output logic                          alu_req,
    output logic [OP_W-1:0]               alu_op,
    output logic [7:0]                    alu_a,
    output logic [7:0]                    alu_b,
    input  logic                          alu_done,
    input  logic [7:0]                    alu_result,
    input  logic [3:0]                    alu_flags,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [7:0]                    rsp_result,
    output logic [3:0]                    rsp_flags,
    output logic                          rsp_timeout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       TIMER_LOAD = 8'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]       state;
    logic [7:0]       timer;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    logic [OP_W-1:0]  fifo_op [FIFO_DEPTH];
    logic [7:0]       fifo_a  [FIFO_DEPTH];
    logic [7:0]       fifo_b  [FIFO_DEPTH];

    // No bypass: a full FIFO refuses even when the head is popped this cycle.
    assign cmd_ready = !rst && (fifo_count < DEPTH_C);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == ST_IDLE) && (fifo_count != '0);

    assign alu_req   = (state == ST_ISSUE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr] <= cmd_op;
            fifo_a[wr_ptr]  <= cmd_a;
            fifo_b[wr_ptr]  <= cmd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Timer counts down from TIMEOUT-1 so terminal count lands on the TIMEOUT-th WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        alu_op <= fifo_op[rd_ptr];
                        alu_a  <= fifo_a[rd_ptr];
                        alu_b  <= fifo_b[rd_ptr];
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= TIMER_LOAD;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        rsp_result  <= alu_result;
                        rsp_flags   <= alu_flags;
                        rsp_timeout <= 1'b0;
                        state       <= ST_RESP;
                    end else if (timer == '0) begin
                        rsp_result  <= '0;
                        rsp_flags   <= '0;
                        rsp_timeout <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model (command queue + in-flight op age).
module tb_alu_op_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int OP_W       = 4;
    localparam int TIMEOUT    = 15;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op = '0;
    logic [7:0]       cmd_a = '0;
    logic [7:0]       cmd_b = '0;
    logic             alu_req;
    logic [OP_W-1:0]  alu_op;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic             alu_done = 1'b0;
    logic [7:0]       alu_result = '0;
    logic [3:0]       alu_flags = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [7:0]       rsp_result;
    logic [3:0]       rsp_flags;
    logic             rsp_timeout;
    logic             busy;
    logic [CNT_W-1:0] fifo_count;

    alu_op_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .OP_W(OP_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int req_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [7:0]      a;
        logic [7:0]      b;
    } cmd_t;

    cmd_t       m_q[$];
    cmd_t       m_cur = '0;
    bit         m_inflight = 1'b0;
    bit         m_rsp_pend = 1'b0;
    int         m_age = 0;      // cycles since the op was popped; 1 = request cycle
    logic [7:0] m_res = '0;
    logic [3:0] m_flg = '0;
    logic       m_to = 1'b0;

    always @(posedge clk) begin : model
        bit   acc;
        cmd_t nc;
        if (rst) begin
            m_q.delete();
            m_cur = '0;
            m_inflight = 1'b0;
            m_rsp_pend = 1'b0;
            m_age = 0;
            m_res = '0;
            m_flg = '0;
            m_to = 1'b0;
        end else begin
            acc = cmd_valid && (m_q.size() < FIFO_DEPTH);
            if (m_rsp_pend) begin
                if (rsp_ready) m_rsp_pend = 1'b0;
            end else if (m_inflight) begin
                if (m_age >= 2 && alu_done) begin
                    m_res = alu_result; m_flg = alu_flags; m_to = 1'b0;
                    m_inflight = 1'b0; m_rsp_pend = 1'b1;
                end else if (m_age >= 2 && (m_age - 1) == TIMEOUT) begin
                    m_res = '0; m_flg = '0; m_to = 1'b1;
                    m_inflight = 1'b0; m_rsp_pend = 1'b1;
                end else begin
                    m_age++;
                end
            end else if (m_q.size() != 0) begin
                m_cur = m_q.pop_front();
                m_inflight = 1'b1;
                m_age = 1;
            end
            if (acc) begin
                nc.op = cmd_op; nc.a = cmd_a; nc.b = cmd_b;
                m_q.push_back(nc);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready",   32'(cmd_ready),   32'(!rst && (m_q.size() < FIFO_DEPTH)));
            chk("fifo_count",  32'(fifo_count),  32'(m_q.size()));
            chk("busy",        32'(busy),        32'(m_inflight || m_rsp_pend || (m_q.size() != 0)));
            chk("alu_req",     32'(alu_req),     32'(m_inflight && m_age == 1));
            chk("alu_op",      32'(alu_op),      32'(m_cur.op));
            chk("alu_a",       32'(alu_a),       32'(m_cur.a));
            chk("alu_b",       32'(alu_b),       32'(m_cur.b));
            chk("rsp_valid",   32'(rsp_valid),   32'(m_rsp_pend));
            chk("rsp_result",  32'(rsp_result),  32'(m_res));
            chk("rsp_flags",   32'(rsp_flags),   32'(m_flg));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
            if (alu_req) req_count++;
        end
    end

    // ---------------- ALU core responder ----------------
    int         alu_mode = 0;   // <0 random, 0 never answers, >0 answers in that WAIT cycle
    bit         spurious = 1'b0;
    bit         armed = 1'b0;
    int         wait_k = 0;
    int         wait_d = 0;
    logic [7:0] pend_res = '0;
    logic [3:0] pend_flg = '0;

    always begin
        @(posedge clk); #1;
        if (alu_req) begin
            armed = 1'b1;
            wait_k = 0;
            alu_done = 1'b0;
            if (alu_mode < 0) begin
                case ($urandom_range(0, 6))
                    0:       wait_d = TIMEOUT;
                    1:       wait_d = 1000;
                    2:       wait_d = TIMEOUT + 1;
                    default: wait_d = int'($urandom_range(1, TIMEOUT));
                endcase
                pend_res = 8'($urandom);
                pend_flg = 4'($urandom);
            end else begin
                wait_d = (alu_mode == 0) ? 1000 : alu_mode;
                pend_res = alu_a + alu_b;
                pend_flg = '0;
            end
        end else if (armed) begin
            wait_k++;
            if (wait_k == wait_d) begin
                alu_done = 1'b1;
                alu_result = pend_res;
                alu_flags = pend_flg;
                armed = 1'b0;
            end else begin
                alu_done = 1'b0;
            end
        end else if (spurious && $urandom_range(0, 7) == 0) begin
            alu_done = 1'b1;
            alu_result = 8'($urandom);
            alu_flags = 4'($urandom);
        end else begin
            alu_done = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [OP_W-1:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        for (int i = 0; i < 64; i++) begin
            sample();
            if (cmd_ready) break;
            step();
        end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
            sample();
        end while (!rsp_valid && lat < 200);
        chk("rsp_seen", 32'(rsp_valid), 32'd1);
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step();
            sample();
            if (!busy) break;
        end
        chk("drained", 32'(busy), 32'd0);
        step();
    endtask

    task automatic run_single(input string tag, input logic [OP_W-1:0] op, input logic [7:0] a,
                              input logic [7:0] b, input int mode, input int exp_lat,
                              input logic [7:0] exp_res, input logic exp_to);
        int lat;
        int r0;
        alu_mode = mode;
        rsp_ready = 1'b1;
        r0 = req_count;
        send_cmd(op, a, b);
        sample();
        chk({tag, "_req_early"}, 32'(alu_req), 32'd0);
        chk({tag, "_count1"}, 32'(fifo_count), 32'd1);
        step();
        sample();
        chk({tag, "_req"}, 32'(alu_req), 32'd1);
        chk({tag, "_op"}, 32'(alu_op), 32'(op));
        chk({tag, "_a"}, 32'(alu_a), 32'(a));
        chk({tag, "_b"}, 32'(alu_b), 32'(b));
        wait_rsp(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
        chk({tag, "_flags"}, 32'(rsp_flags), 32'd0);
        chk({tag, "_timeout"}, 32'(rsp_timeout), 32'(exp_to));
        step();
        sample();
        chk({tag, "_valid_clear"}, 32'(rsp_valid), 32'd0);
        step();
        chk({tag, "_req_pulses"}, 32'(req_count - r0), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        int         acc;
        int         n;
        int         r0;
        int         lat;
        logic [7:0] got_res [5];
        logic       got_to  [5];

        step();
        chk_en = 1'b1;
        step();
        sample();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        sample();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_count", 32'(fifo_count), 32'd0);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_alu_req", 32'(alu_req), 32'd0);
        step();

        // single op answered in WAIT cycle 3
        run_single("t1", 4'd0, 8'h12, 8'h34, 3, 4, 8'h46, 1'b0);
        // ALU silent: timeout
        run_single("t3", 4'd5, 8'h77, 8'h11, 0, TIMEOUT + 1, 8'h00, 1'b1);
        // done in the last permitted WAIT cycle beats the timeout
        run_single("t5", 4'd9, 8'h50, 8'h55, TIMEOUT, TIMEOUT + 1, 8'hA5, 1'b0);

        // capacity: 4 queued + 1 in flight, then ordered release
        alu_mode = 0;
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 25; c++) begin
            cmd_valid = 1'b1;
            cmd_op = 4'(acc);
            cmd_a = 8'(16 * acc + 1);
            cmd_b = 8'(acc + 3);
            sample();
            if (cmd_valid && cmd_ready) acc++;
            step();
        end
        cmd_valid = 1'b0;
        sample();
        chk("t2_accepted", 32'(acc), 32'd5);
        chk("t2_full_count", 32'(fifo_count), 32'd4);
        chk("t2_full_ready", 32'(cmd_ready), 32'd0);
        chk("t2_first_timeout", 32'(rsp_timeout), 32'd1);
        alu_mode = 2;
        rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 300 && n < 5; i++) begin
            if (rsp_valid) begin
                got_res[n] = rsp_result;
                got_to[n] = rsp_timeout;
                n++;
            end
            step();
            sample();
        end
        chk("t2_rsp_count", 32'(n), 32'd5);
        chk("t2_rsp0_to", 32'(got_to[0]), 32'd1);
        chk("t2_rsp0_res", 32'(got_res[0]), 32'd0);
        for (int i = 1; i < 5; i++) begin
            chk("t2_rsp_to", 32'(got_to[i]), 32'd0);
            chk("t2_rsp_res", 32'(got_res[i]), 32'(8'(16 * i + 1 + i + 3)));
        end
        drain();

        // response back-pressure holds everything
        rsp_ready = 1'b0;
        alu_mode = 3;
        for (int i = 0; i < 3; i++) send_cmd(4'(i), 8'(8'h20 + i), 8'h01);
        wait_rsp(lat);
        step();
        r0 = req_count;
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("t4_valid", 32'(rsp_valid), 32'd1);
            chk("t4_result", 32'(rsp_result), 32'h21);
            chk("t4_timeout", 32'(rsp_timeout), 32'd0);
            chk("t4_count", 32'(fifo_count), 32'd2);
            step();
        end
        chk("t4_no_req", 32'(req_count - r0), 32'd0);
        drain();

        // reset during WAIT with 2 queued; ALU answers after the reset
        alu_mode = 6;
        rsp_ready = 1'b1;
        send_cmd(4'd1, 8'h01, 8'h02);
        send_cmd(4'd2, 8'h03, 8'h04);
        send_cmd(4'd3, 8'h05, 8'h06);
        sample();
        chk("t6_pre_count", 32'(fifo_count), 32'd2);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        r0 = req_count;
        for (int i = 0; i < 12; i++) begin
            sample();
            chk("t6_count", 32'(fifo_count), 32'd0);
            chk("t6_busy", 32'(busy), 32'd0);
            chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
            step();
        end
        chk("t6_no_req", 32'(req_count - r0), 32'd0);

        // randomized traffic
        alu_mode = -1;
        spurious = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 599) == 0);
            cmd_valid = ($urandom_range(0, 1) == 1);
            cmd_op = 4'($urandom);
            cmd_a = 8'($urandom);
            cmd_b = 8'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 6);
        end
        step();
        rst = 1'b0;
        spurious = 1'b0;
        alu_mode = 2;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
